// File: rtl/aline_seq_pkg.sv
// Shared state encoding and default timing constants for the A-line sequencer.
// Pure declarations: no latency, no backpressure.
package aline_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_FIRE,
        ST_ACQ,
        ST_NEXT
    } state_e;

    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_PULSE_CYC  = 32;
    localparam int DEF_ACQ_CYC    = 2000;

endpackage

// File: rtl/pulse_serializer.sv
// MSB-first transmit pattern shifter; bit 31 is visible the cycle after load.
// Shifts one bit per shift_en cycle with no backpressure; last flags bit PULSE_CYC-1.
module pulse_serializer
    import aline_seq_pkg::*;
#(
    parameter int PULSE_CYC = DEF_PULSE_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift_en,
    input  logic [31:0] pulse_shape,
    output logic        tx_bit,
    output logic        last
);

    logic [31:0] shreg_q;
    logic [5:0]  bit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            shreg_q   <= pulse_shape;
            bit_cnt_q <= '0;
        end else if (shift_en) begin
            shreg_q   <= {shreg_q[30:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 6'd1;
        end
    end

    assign tx_bit = shreg_q[31];
    assign last   = (bit_cnt_q == 6'(PULSE_CYC - 1));

endmodule

// File: rtl/aline_sequencer.sv
// Frame controller: LOAD -> WAIT -> FIRE -> ACQ -> NEXT per A-line, all outputs registered (Moore).
// Per-line cost 1+SETTLE+PULSE+ACQ+1 cycles; abort or config intake kills the frame on the next edge.
module aline_sequencer
    import aline_seq_pkg::*;
#(
    parameter int ALINE_W    = 4,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int ACQ_CYC    = DEF_ACQ_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ALINE_W:0]   num_alines,
    input  logic               intaking_configs,
    input  logic               updating_delays,
    input  logic [31:0]        pulse_shape,
    output logic [ALINE_W-1:0] which_aline,
    output logic               rd_en,
    output logic               tx_bit,
    output logic               tx_active,
    output logic               acq_en,
    output logic               busy,
    output logic               aline_done,
    output logic               frame_done,
    output logic               cfg_err
);

    localparam logic [ALINE_W:0] MAX_LINES = {1'b1, {ALINE_W{1'b0}}};

    state_e             state_q, state_d;
    logic [ALINE_W-1:0] idx_q, idx_d;
    logic [ALINE_W:0]   count_q, count_d;
    logic [15:0]        settle_q, settle_d;
    logic [15:0]        acq_q, acq_d;
    logic               intake_prev_q;
    logic               rd_en_q, tx_active_q, acq_en_q, busy_q;
    logic               aline_done_q, frame_done_q, frame_done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               intake_rise, kill, last_line;
    logic [ALINE_W:0]   num_clamped;
    logic               ser_bit, ser_last, ser_load, ser_shift;

    assign intake_rise = intaking_configs & ~intake_prev_q;
    assign kill        = abort | (intake_rise & (state_q != ST_IDLE));
    assign last_line   = (({1'b0, idx_q} + (ALINE_W+1)'(1)) == count_q);
    assign num_clamped = (num_alines > MAX_LINES) ? MAX_LINES : num_alines;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        settle_d     = '0;
        acq_d        = '0;
        frame_done_d = 1'b0;
        cfg_err_d    = intake_rise & (state_q != ST_IDLE);
        if (kill) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !intaking_configs) begin
                        idx_d   = '0;
                        count_d = num_clamped;
                        if (num_clamped == '0) frame_done_d = 1'b1;
                        else                   state_d      = ST_LOAD;
                    end
                end
                ST_LOAD: state_d = ST_WAIT;
                ST_WAIT: begin
                    // any delay rewrite restarts the quiet period from zero
                    if (updating_delays)                          settle_d = '0;
                    else if (settle_q == 16'(SETTLE_CYC - 1))     state_d  = ST_FIRE;
                    else                                          settle_d = settle_q + 16'd1;
                end
                ST_FIRE: begin
                    if (ser_last) state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (acq_q == 16'(ACQ_CYC - 1)) begin
                        state_d      = ST_NEXT;
                        frame_done_d = last_line;
                    end else begin
                        acq_d = acq_q + 16'd1;
                    end
                end
                ST_NEXT: begin
                    if (last_line) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + ALINE_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ser_load  = (state_q == ST_WAIT) && (state_d == ST_FIRE);
    assign ser_shift = (state_q == ST_FIRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            count_q       <= '0;
            settle_q      <= '0;
            acq_q         <= '0;
            intake_prev_q <= 1'b0;
            rd_en_q       <= 1'b0;
            tx_active_q   <= 1'b0;
            acq_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            aline_done_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            settle_q      <= settle_d;
            acq_q         <= acq_d;
            intake_prev_q <= intaking_configs;
            rd_en_q       <= (state_d == ST_LOAD);
            tx_active_q   <= (state_d == ST_FIRE);
            acq_en_q      <= (state_d == ST_ACQ);
            busy_q        <= (state_d != ST_IDLE);
            aline_done_q  <= (state_d == ST_NEXT);
            frame_done_q  <= frame_done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    pulse_serializer #(
        .PULSE_CYC (PULSE_CYC)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (ser_load),
        .shift_en    (ser_shift),
        .pulse_shape (pulse_shape),
        .tx_bit      (ser_bit),
        .last        (ser_last)
    );

    // the shifter keeps stale bits after a kill; gate so tx_bit is 0 outside FIRE
    assign tx_bit      = ser_bit & tx_active_q;
    assign which_aline = idx_q;
    assign rd_en       = rd_en_q;
    assign tx_active   = tx_active_q;
    assign acq_en      = acq_en_q;
    assign busy        = busy_q;
    assign aline_done  = aline_done_q;
    assign frame_done  = frame_done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_aline_sequencer.sv
// Scoreboard bench for aline_sequencer: directed frames push expected events,
// a negedge monitor pops and compares each event the DUT emits.
module tb_aline_sequencer;

    localparam int ALINE_W = 4;
    localparam int LINE    = 2042;

    logic               clk = 1'b0;
    logic               rst, start, abort, intaking_configs, updating_delays;
    logic [ALINE_W:0]   num_alines;
    logic [31:0]        pulse_shape;
    logic [ALINE_W-1:0] which_aline;
    logic               rd_en, tx_bit, tx_active, acq_en, busy;
    logic               aline_done, frame_done, cfg_err;

    aline_sequencer #(.ALINE_W(ALINE_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .num_alines       (num_alines),
        .intaking_configs (intaking_configs),
        .updating_delays  (updating_delays),
        .pulse_shape      (pulse_shape),
        .which_aline      (which_aline),
        .rd_en            (rd_en),
        .tx_bit           (tx_bit),
        .tx_active        (tx_active),
        .acq_en           (acq_en),
        .busy             (busy),
        .aline_done       (aline_done),
        .frame_done       (frame_done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_RD, EV_TX, EV_AD, EV_FD, EV_CFG} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [63:0] dat;
        int          at;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic void push(ev_kind_e k, logic [63:0] d, int at);
        ev_t e;
        e.kind = k;
        e.dat  = d;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    // RD at t0, TX burst 9+extra cycles later, aline_done at end of ACQ
    function automatic void push_line(int idx, int t0, int extra, logic [31:0] ps, logic last);
        push(EV_RD, 64'(idx), t0);
        push(EV_TX, {32'd32, ps}, t0 + 9 + extra);
        push(EV_AD, 64'(last), t0 + 2041 + extra);
    endfunction

    function automatic void observe(ev_kind_e k, logic [63:0] d, int at);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got %s dat=%0h at cycle %0d, required none", k.name(), d, at);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.dat !== d || e.at != at) begin
                n_errors++;
                $display("FAIL event_%s: got %s dat=%0h cycle %0d, required %s dat=%0h cycle %0d",
                         e.kind.name(), k.name(), d, at, e.kind.name(), e.dat, e.at);
            end
        end
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // monitor
    logic        in_burst = 1'b0;
    int          b_start, b_len;
    logic [31:0] b_bits;
    logic        overlap_seen = 1'b0;

    always @(negedge clk) begin
        if (tx_active === 1'b1 && updating_delays === 1'b1) overlap_seen = 1'b1;
        if (tx_active === 1'b1) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                b_start  = cyc;
                b_len    = 0;
                b_bits   = '0;
            end
            b_bits = {b_bits[30:0], tx_bit};
            b_len++;
        end else if (in_burst) begin
            in_burst = 1'b0;
            observe(EV_TX, {32'(b_len), b_bits}, b_start);
        end
        if (rd_en === 1'b1) observe(EV_RD, 64'(which_aline), cyc);
        if (aline_done === 1'b1)      observe(EV_AD, 64'(frame_done), cyc);
        else if (frame_done === 1'b1) observe(EV_FD, 64'd1, cyc);
        if (cfg_err === 1'b1) observe(EV_CFG, 64'(busy), cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic kick(input int num, input logic [31:0] ps);
        num_alines  = num[ALINE_W:0];
        pulse_shape = ps;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({which_aline, rd_en, tx_bit, tx_active, acq_en, busy, aline_done, frame_done, cfg_err});
    endfunction

    int s;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        intaking_configs = 1'b0; updating_delays = 1'b0;
        num_alines = '0; pulse_shape = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_outputs", all_outs(), 64'd0);

        // three-line frame
        s = cyc;
        for (int n = 0; n < 3; n++) push_line(n, s + 1 + LINE * n, 0, 32'hDEADBEEF, n == 2);
        kick(3, 32'hDEADBEEF);
        wait_until(s + 3 * LINE + 2);
        check("busy_after_frame", 64'(busy), 64'd0);

        // pulse serialisation
        s = cyc;
        push_line(0, s + 1, 0, 32'hA5000001, 1'b1);
        kick(1, 32'hA5000001);
        wait_until(s + LINE + 3);

        // settle wait restarted by delay update
        s = cyc;
        push_line(0, s + 1, 5, 32'h80000003, 1'b1);
        kick(1, 32'h80000003);
        wait_until(s + 2);
        updating_delays = 1'b1;
        wait_until(s + 7);
        updating_delays = 1'b0;
        wait_until(s + LINE + 8);
        check("tx_during_update", 64'(overlap_seen), 64'd0);

        // abort 100 cycles into ACQ of line 1
        s = cyc;
        push_line(0, s + 1, 0, 32'h12345678, 1'b0);
        push(EV_RD, 64'd1, s + 1 + LINE);
        push(EV_TX, {32'd32, 32'h12345678}, s + 10 + LINE);
        kick(3, 32'h12345678);
        wait_until(s + LINE + 1 + 41 + 100);
        check("acq_before_abort", 64'(acq_en), 64'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("acq_after_abort", 64'(acq_en), 64'd0);
        check("busy_after_abort", 64'(busy), 64'd0);
        wait_until(s + 2 * LINE + 50);
        s = cyc;
        push_line(0, s + 1, 0, 32'h0000FFFF, 1'b1);
        kick(1, 32'h0000FFFF);
        wait_until(s + LINE + 3);

        // config intake kills frame during WAIT
        s = cyc;
        push(EV_RD, 64'd0, s + 1);
        push(EV_CFG, 64'd0, s + 5);
        kick(2, 32'h0F0F0F0F);
        wait_until(s + 4);
        intaking_configs = 1'b1;
        tick(1);
        check("busy_after_cfg_kill", 64'(busy), 64'd0);
        wait_until(s + 8);
        kick(2, 32'h0F0F0F0F);
        tick(3);
        check("start_during_intake", 64'(busy), 64'd0);
        intaking_configs = 1'b0;
        tick(2);

        // degenerate zero-line frame
        s = cyc;
        push(EV_FD, 64'd1, s + 1);
        kick(0, 32'h0F0F0F0F);
        tick(5);
        check("busy_zero_lines", 64'(busy), 64'd0);

        // reset during FIRE
        s = cyc;
        push(EV_RD, 64'd0, s + 1);
        push(EV_TX, {32'd6, 32'h0000003C}, s + 10);
        kick(1, 32'hF0F0F0F0);
        wait_until(s + 15);
        rst = 1'b1;
        tick(1);
        check("outputs_after_mid_rst", all_outs(), 64'd0);
        rst = 1'b0;
        tick(3);

        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
